// File: rtl/ppu_pkg.sv
// Shared constants and helpers for the NES PPU register block: register
// indices, frame geometry, PPUDATA engine states and the palette mirror map.
package ppu_pkg;

    localparam logic [2:0] PPUCTRL   = 3'd0;
    localparam logic [2:0] PPUMASK   = 3'd1;
    localparam logic [2:0] PPUSTATUS = 3'd2;
    localparam logic [2:0] OAMADDR   = 3'd3;
    localparam logic [2:0] OAMDATA   = 3'd4;
    localparam logic [2:0] PPUSCROLL = 3'd5;
    localparam logic [2:0] PPUADDR   = 3'd6;
    localparam logic [2:0] PPUDATA   = 3'd7;

    localparam logic [8:0] DOTS     = 9'd341;
    localparam logic [8:0] LINES    = 9'd262;
    localparam logic [8:0] VBL_LINE = 9'd241;
    localparam logic [8:0] PRE_LINE = 9'd261;

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_ADDR_W,
        ENG_WRITE,
        ENG_ADDR_R,
        ENG_READ
    } eng_state_t;

    // Sprite backdrop entries $10/$14/$18/$1C alias the background ones.
    function automatic logic [4:0] pal_index(input logic [4:0] a);
        return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
    endfunction

endpackage

// File: rtl/ppu_timing.sv
// Dot/scanline counters for one 341x262 frame; emits single-cycle pulses in
// the cycle before the vblank flag must set (241,1) and clear (261,1).
module ppu_timing
    import ppu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic vbl_set,
    output logic vbl_clr
);

    logic [8:0] dot;
    logic [8:0] line;

    always_ff @(posedge clk) begin
        if (rst) begin
            dot  <= 9'd0;
            line <= 9'd0;
        end else if (dot == DOTS - 9'd1) begin
            dot  <= 9'd0;
            line <= (line == LINES - 9'd1) ? 9'd0 : line + 9'd1;
        end else begin
            dot <= dot + 9'd1;
        end
    end

    assign vbl_set = (line == VBL_LINE) && (dot == 9'd0);
    assign vbl_clr = (line == PRE_LINE) && (dot == 9'd0);

endmodule

// File: rtl/nes_ppu_regs.sv
// NES PPU CPU-visible register file with scroll registers, OAM, palette,
// internal nametable RAM, vblank/NMI and the PPUDATA bus access engine.
module nes_ppu_regs
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cpubus_address_i,
    input  logic [7:0]  cpubus_data_i,
    output logic [7:0]  cpubus_data_o,
    input  logic        cpubus_rw_i,
    input  logic        cpubus_ce_i,
    output logic [13:0] ppubus_address_o,
    output logic [7:0]  ppubus_data_o,
    input  logic [7:0]  ppubus_data_i,
    output logic        ppubus_rw_o,
    input  logic        vram_ce,
    input  logic        vram_a10,
    output logic        nmi_o,
    output logic [4:0]  color_o
);

    // CPU side: cpubus_ce_i is a one-cycle strobe that is always accepted
    // (no ready); the access and all its side effects commit on that edge.
    logic [7:0]  ctrl, mask, oamaddr, buffer, openbus, nt_q;
    logic [14:0] v, t;
    logic [2:0]  x;
    logic        w, vblank;
    logic        vbl_set, vbl_clr;

    logic [7:0]  oam     [256];
    logic [5:0]  palette [32];
    logic [7:0]  nt_ram  [2048];

    eng_state_t  eng_state, eng_next;
    logic [13:0] bus_addr;
    logic [7:0]  bus_wdata;

    logic        cpu_rd, cpu_wr, pal_sel, data_sel, start_rd, start_wr;
    logic [4:0]  pal_idx;
    logic [14:0] v_inc;
    logic        unused_regs;

    ppu_timing u_timing (
        .clk     (clk),
        .rst     (rst),
        .vbl_set (vbl_set),
        .vbl_clr (vbl_clr)
    );

    assign cpu_rd   = cpubus_ce_i & cpubus_rw_i;
    assign cpu_wr   = cpubus_ce_i & ~cpubus_rw_i;
    assign data_sel = cpubus_address_i == PPUDATA;
    assign pal_sel  = v[13:8] == 6'h3F;
    assign pal_idx  = pal_index(v[4:0]);
    assign v_inc    = ctrl[2] ? 15'd32 : 15'd1;
    assign start_rd = (eng_state == ENG_IDLE) && cpu_rd && data_sel;
    assign start_wr = (eng_state == ENG_IDLE) && cpu_wr && data_sel && !pal_sel;

    always_comb begin
        cpubus_data_o = openbus;
        case (cpubus_address_i)
            PPUSTATUS: cpubus_data_o = {vblank, 2'b00, openbus[4:0]};
            OAMDATA:   cpubus_data_o = oam[oamaddr];
            PPUDATA:   cpubus_data_o = pal_sel ? {2'b00, palette[pal_idx]} : buffer;
            default:   cpubus_data_o = openbus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= 8'h00;
            mask    <= 8'h00;
            oamaddr <= 8'h00;
            openbus <= 8'h00;
            v       <= 15'h0000;
            t       <= 15'h0000;
            x       <= 3'd0;
            w       <= 1'b0;
            vblank  <= 1'b0;
        end else begin
            // The set edge wins over a coincident $2002 read clear.
            if (vbl_set)
                vblank <= 1'b1;
            else if (vbl_clr || (cpu_rd && cpubus_address_i == PPUSTATUS))
                vblank <= 1'b0;

            if (cpubus_ce_i)
                openbus <= cpu_rd ? cpubus_data_o : cpubus_data_i;

            if (cpu_wr) begin
                case (cpubus_address_i)
                    PPUCTRL: begin
                        ctrl      <= cpubus_data_i;
                        t[11:10]  <= cpubus_data_i[1:0];
                    end
                    PPUMASK: mask    <= cpubus_data_i;
                    OAMADDR: oamaddr <= cpubus_data_i;
                    OAMDATA: oamaddr <= oamaddr + 8'd1;
                    PPUSCROLL: begin
                        if (!w) begin
                            t[4:0] <= cpubus_data_i[7:3];
                            x      <= cpubus_data_i[2:0];
                        end else begin
                            t[14:12] <= cpubus_data_i[2:0];
                            t[9:5]   <= cpubus_data_i[7:3];
                        end
                        w <= ~w;
                    end
                    PPUADDR: begin
                        if (!w) begin
                            t[13:8] <= cpubus_data_i[5:0];
                            t[14]   <= 1'b0;
                        end else begin
                            t[7:0] <= cpubus_data_i;
                            v      <= {t[14:8], cpubus_data_i};
                        end
                        w <= ~w;
                    end
                    PPUDATA: v <= v + v_inc;
                    default: ;
                endcase
            end

            if (cpu_rd) begin
                case (cpubus_address_i)
                    PPUSTATUS: w <= 1'b0;
                    PPUDATA:   v <= v + v_inc;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && cpu_wr && cpubus_address_i == OAMDATA)
            oam[oamaddr] <= cpubus_data_i;
        if (!rst && cpu_wr && data_sel && pal_sel)
            palette[pal_idx] <= cpubus_data_i[5:0];
    end

    // PPUDATA engine: address cycle, then either a one-cycle write strobe or
    // a data cycle whose result lands in the read buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_state <= ENG_IDLE;
            bus_addr  <= 14'h0000;
            bus_wdata <= 8'h00;
            buffer    <= 8'h00;
        end else begin
            eng_state <= eng_next;
            if (start_rd)
                bus_addr <= pal_sel ? (v[13:0] & 14'h2FFF) : v[13:0];
            if (start_wr) begin
                bus_addr  <= v[13:0];
                bus_wdata <= cpubus_data_i;
            end
            if (eng_state == ENG_READ)
                buffer <= vram_ce ? nt_q : ppubus_data_i;
        end
    end

    always_comb begin
        eng_next = eng_state;
        case (eng_state)
            ENG_IDLE: begin
                if (start_rd)
                    eng_next = ENG_ADDR_R;
                else if (start_wr)
                    eng_next = ENG_ADDR_W;
            end
            ENG_ADDR_W: eng_next = ENG_WRITE;
            ENG_WRITE:  eng_next = ENG_IDLE;
            ENG_ADDR_R: eng_next = ENG_READ;
            ENG_READ:   eng_next = ENG_IDLE;
            default:    eng_next = ENG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && eng_state == ENG_WRITE && vram_ce)
            nt_ram[{vram_a10, bus_addr[9:0]}] <= bus_wdata;
        if (!rst && eng_state == ENG_ADDR_R)
            nt_q <= nt_ram[{vram_a10, bus_addr[9:0]}];
    end

    assign ppubus_address_o = bus_addr;
    assign ppubus_data_o    = bus_wdata;
    assign ppubus_rw_o      = (eng_state != ENG_WRITE) || vram_ce;
    assign nmi_o            = vblank & ctrl[7];
    assign color_o          = (mask[4:3] == 2'b00 && pal_sel) ? v[4:0] : 5'd0;

    assign unused_regs = ^{ctrl[6:3], ctrl[1:0], mask[7:5], mask[2:0], x, t[7:0]};

endmodule

// File: tb/tb_nes_ppu_regs.sv
// Directed bench for nes_ppu_regs: vblank/NMI, scroll/address registers,
// PPUDATA bus cycles, palette, OAM, internal nametable RAM and reset abort.
module tb_nes_ppu_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cpubus_address_i = 3'd0;
    logic [7:0]  cpubus_data_i = 8'h00;
    logic [7:0]  cpubus_data_o;
    logic        cpubus_rw_i = 1'b1;
    logic        cpubus_ce_i = 1'b0;
    logic [13:0] ppubus_address_o;
    logic [7:0]  ppubus_data_o;
    logic [7:0]  ppubus_data_i;
    logic        ppubus_rw_o;
    logic        vram_ce = 1'b0;
    logic        vram_a10 = 1'b0;
    logic        nmi_o;
    logic [4:0]  color_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  ext_mem [16384];
    logic [21:0] exp_q [$];
    logic [21:0] obs_q [$];
    logic [7:0]  rd;

    nes_ppu_regs dut (
        .clk              (clk),
        .rst              (rst),
        .cpubus_address_i (cpubus_address_i),
        .cpubus_data_i    (cpubus_data_i),
        .cpubus_data_o    (cpubus_data_o),
        .cpubus_rw_i      (cpubus_rw_i),
        .cpubus_ce_i      (cpubus_ce_i),
        .ppubus_address_o (ppubus_address_o),
        .ppubus_data_o    (ppubus_data_o),
        .ppubus_data_i    (ppubus_data_i),
        .ppubus_rw_o      (ppubus_rw_o),
        .vram_ce          (vram_ce),
        .vram_a10         (vram_a10),
        .nmi_o            (nmi_o),
        .color_o          (color_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // cartridge bus model: read data valid the cycle after the address
    always @(posedge clk) begin
        ppubus_data_i <= ext_mem[ppubus_address_o];
        if (ppubus_rw_o === 1'b0)
            ext_mem[ppubus_address_o] <= ppubus_data_o;
    end

    // every low cycle of the write strobe is one observed bus write
    always @(negedge clk) begin
        if (ppubus_rw_o === 1'b0)
            obs_q.push_back({ppubus_address_o, ppubus_data_o});
    end

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 24'(obs_q.size()), 24'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_addr_data"}, 24'(obs_q.pop_front()), 24'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
    endtask

    // driver tasks: start at a negedge, strobe for one cycle, idle two more
    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        cpubus_address_i = a;
        cpubus_data_i    = d;
        cpubus_rw_i      = 1'b0;
        cpubus_ce_i      = 1'b1;
        @(negedge clk);
        cpubus_ce_i = 1'b0;
        cpubus_rw_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        cpubus_address_i = a;
        cpubus_rw_i      = 1'b1;
        cpubus_ce_i      = 1'b1;
        #1;
        d = cpubus_data_o;
        @(negedge clk);
        cpubus_ce_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ext_mem[i] = 8'(i) ^ 8'hA5;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rw", 24'(ppubus_rw_o), 24'h1);
        check("rst_addr", 24'(ppubus_address_o), 24'h0);
        check("rst_wdata", 24'(ppubus_data_o), 24'h0);
        check("rst_nmi", 24'(nmi_o), 24'h0);
        check("rst_color", 24'(color_o), 24'h0);
        check("rst_openbus", 24'(cpubus_data_o), 24'h0);
        check("rst_v", 24'(dut.v), 24'h0);
        rst = 1'b0;

        // vblank sets on the edge into scanline 241 dot 1
        repeat (241 * 341) @(negedge clk);
        check("vbl_before", 24'(dut.vblank), 24'h0);
        cpu_rd(3'd2, rd);
        check("status_at_set", 24'(rd), 24'h00);
        check("vbl_after", 24'(dut.vblank), 24'h1);
        check("nmi_disabled", 24'(nmi_o), 24'h0);
        cpu_wr(3'd0, 8'h80);
        check("nmi_raise", 24'(nmi_o), 24'h1);
        cpu_wr(3'd3, 8'h15);
        cpu_rd(3'd2, rd);
        check("status_read", 24'(rd), 24'h95);
        check("vbl_cleared", 24'(dut.vblank), 24'h0);
        check("nmi_drop", 24'(nmi_o), 24'h0);

        // PPUDATA external write
        cpu_wr(3'd6, 8'h21);
        cpu_wr(3'd6, 8'h08);
        exp_q.push_back({14'h2108, 8'h5A});
        cpu_wr(3'd7, 8'h5A);
        check_writes("wr_2108");
        check("v_2109", 24'(dut.v), 24'h2109);
        check("mem_2108", 24'(ext_mem[14'h2108]), 24'h5A);

        // PPUDATA buffered reads
        ext_mem[14'h2400] = 8'h33;
        cpu_wr(3'd6, 8'h24);
        cpu_wr(3'd6, 8'h00);
        cpu_rd(3'd7, rd);
        check("rd_stale", 24'(rd), 24'h00);
        cpu_rd(3'd7, rd);
        check("rd_2400", 24'(rd), 24'h33);
        check("v_2402", 24'(dut.v), 24'h2402);
        cpu_rd(3'd7, rd);
        check("rd_2401", 24'(rd), 24'hA4);
        check("addr_hold", 24'(ppubus_address_o), 24'h2402);

        // +32 increment, palette write/read and mirror
        cpu_wr(3'd0, 8'h04);
        cpu_wr(3'd6, 8'h20);
        cpu_wr(3'd6, 8'h00);
        exp_q.push_back({14'h2000, 8'h77});
        cpu_wr(3'd7, 8'h77);
        check_writes("wr_2000");
        check("v_inc32", 24'(dut.v), 24'h2020);
        cpu_wr(3'd6, 8'h3F);
        cpu_wr(3'd6, 8'h10);
        cpu_wr(3'd7, 8'h2A);
        check_writes("pal_no_bus");
        cpu_wr(3'd6, 8'h3F);
        cpu_wr(3'd6, 8'h00);
        cpu_rd(3'd7, rd);
        check("pal_3f00", 24'(rd), 24'h2A);
        cpu_wr(3'd6, 8'h3F);
        cpu_wr(3'd6, 8'h04);
        cpu_wr(3'd7, 8'h11);
        cpu_wr(3'd6, 8'h3F);
        cpu_wr(3'd6, 8'h14);
        cpu_rd(3'd7, rd);
        check("pal_3f14", 24'(rd), 24'h11);
        cpu_wr(3'd6, 8'h20);
        cpu_wr(3'd6, 8'h00);
        cpu_rd(3'd7, rd);
        check("buf_shadow_2f14", 24'(rd), 24'hB1);

        // color_o follows v in palette space only while rendering is off
        cpu_wr(3'd0, 8'h00);
        cpu_wr(3'd6, 8'h3F);
        cpu_wr(3'd6, 8'h05);
        check("color_pal", 24'(color_o), 24'h05);
        cpu_wr(3'd1, 8'h08);
        check("color_bg_on", 24'(color_o), 24'h00);
        cpu_wr(3'd1, 8'h00);

        // scroll writes and w reset
        cpu_wr(3'd0, 8'h00);
        cpu_wr(3'd5, 8'h7D);
        check("w_first", 24'(dut.w), 24'h1);
        check("fine_x", 24'(dut.x), 24'h5);
        cpu_wr(3'd5, 8'h5E);
        check("t_scroll", 24'(dut.t), 24'h616F);
        check("w_second", 24'(dut.w), 24'h0);
        cpu_wr(3'd5, 8'h00);
        cpu_wr(3'd3, 8'hC7);
        cpu_rd(3'd2, rd);
        check("status_openbus", 24'(rd), 24'h07);
        check("w_status_clr", 24'(dut.w), 24'h0);
        cpu_rd(3'd5, rd);
        check("wo_openbus", 24'(rd), 24'h07);

        // OAM
        cpu_wr(3'd3, 8'h10);
        cpu_wr(3'd4, 8'hAB);
        cpu_wr(3'd4, 8'hCD);
        check("oamaddr_inc", 24'(dut.oamaddr), 24'h12);
        cpu_wr(3'd3, 8'h11);
        cpu_rd(3'd4, rd);
        check("oam_11", 24'(rd), 24'hCD);
        cpu_rd(3'd4, rd);
        check("oam_no_inc", 24'(rd), 24'hCD);

        // internal nametable RAM
        vram_ce  = 1'b1;
        vram_a10 = 1'b1;
        cpu_wr(3'd6, 8'h2C);
        cpu_wr(3'd6, 8'h05);
        cpu_wr(3'd7, 8'hE1);
        check_writes("nt_no_bus");
        check("nt_ram_405", 24'(dut.nt_ram[11'h405]), 24'hE1);
        check("ext_2c05", 24'(ext_mem[14'h2C05]), 24'hA0);
        cpu_wr(3'd6, 8'h2C);
        cpu_wr(3'd6, 8'h05);
        cpu_rd(3'd7, rd);
        cpu_rd(3'd7, rd);
        check("nt_readback", 24'(rd), 24'hE1);
        vram_ce  = 1'b0;
        vram_a10 = 1'b0;

        // reset between the address cycle and the write strobe
        cpu_wr(3'd6, 8'h21);
        cpu_wr(3'd6, 8'h00);
        cpubus_address_i = 3'd7;
        cpubus_data_i    = 8'h99;
        cpubus_rw_i      = 1'b0;
        cpubus_ce_i      = 1'b1;
        @(negedge clk);
        cpubus_ce_i = 1'b0;
        cpubus_rw_i = 1'b1;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check_writes("abort");
        check("abort_rw", 24'(ppubus_rw_o), 24'h1);
        check("abort_addr", 24'(ppubus_address_o), 24'h0);
        check("abort_wdata", 24'(ppubus_data_o), 24'h0);
        check("abort_v", 24'(dut.v), 24'h0);
        check("abort_mem", 24'(ext_mem[14'h2100]), 24'hA5);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
